instr_mem_stream: RTL

- Parametrised successor to the core's instruction memory: DEPTH x DATA_W synchronous-read store feeding the fetch stage.
- Adds a valid/ready request/response handshake with backpressure and a program-load write port.
- Detects out-of-range addresses and keeps a saturating fetch counter.
- Sits between the PC/fetch unit and decode.

---
 rtl/instr_mem_pkg.sv | 17 +
 rtl/instr_mem_array.sv | 43 ++++
 rtl/instr_mem_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared defaults and init-mode
// encodings for the fetch-side instruction memory.
package instr_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;
  localparam int CNT_W_DEF  = 16;

  localparam int INIT_INDEX = 0;
  localparam int INIT_ZERO  = 1;

  function automatic int addr_bits(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: 1R1W synchronous read-before-
// write word store with elaboration-time contents.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int INIT_MODE = INIT_INDEX,
  parameter int AW        = addr_bits(DEPTH)
) (
  input  logic              clock,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      if (INIT_MODE == INIT_ZERO)
        m[i] = '0;
      else
        m[i] = DATA_W'(i);
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  // Non-blocking read and write give read-before-write.
  always_ff @(posedge clock) begin
    if (re)
      rdata <= mem[raddr];
    if (we)
      mem[waddr] <= wdata;
  end

endmodule

// File: rtl/instr_mem_stream.sv
// instr_mem_stream: handshaked instruction fetch
// memory with load port, range checks and counter.
module instr_mem_stream
  import instr_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int INIT_MODE = INIT_INDEX,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int AW = addr_bits(DEPTH);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(DEPTH);

  logic              fire;
  logic              req_in;
  logic              load_in;
  logic              rsp_ok;
  logic [DATA_W-1:0] rdata;

  assign req_ready = !rsp_valid || rsp_ready;
  assign fire      = req_valid && req_ready && !reset;
  assign req_in    = {1'b0, req_addr} < LIMIT;
  assign load_in   = {1'b0, load_addr} < LIMIT;

  instr_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE),
    .AW        (AW)
  ) u_array (
    .clock (clock),
    .re    (fire && req_in),
    .raddr (req_addr[AW-1:0]),
    .rdata (rdata),
    .we    (load_en && load_in && !reset),
    .waddr (load_addr[AW-1:0]),
    .wdata (load_data)
  );

  // rdata only moves on an in-range fire, so the
  // masked output is stable under backpressure.
  assign rsp_instr = rsp_ok ? rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_ok      <= 1'b0;
      load_err    <= 1'b0;
      fetch_count <= '0;
    end else begin
      load_err <= load_en && !load_in;
      if (fire) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !req_in;
        rsp_ok    <= req_in;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (fire && (fetch_count != '1))
        fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule
